// File: rtl/scan_mux_if.sv
// scan_mux_if
//   Output stream of scan_mux: a registered word with valid/ready handshake.
//   Parameters:
//     N     number of channels (only used to size out_sel)
//     W     bits per channel
//   Signals:
//     out_valid  word on out_data/out_sel/out_last is valid (driven by master)
//     out_ready  consumer accepts the word when high with out_valid (driven by slave)
//     out_data   registered channel value
//     out_sel    channel index of out_data
//     out_last   word is the last channel of a scan frame
//   Modports: master = scan_mux side, slave = consumer side.
interface scan_mux_if #(
  parameter int N = 32,
  parameter int W = 1
);
  localparam int SELW = $clog2(N);

  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_sel,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sel,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/scan_mux.sv
// scan_mux
//   Selects one of N W-bit channels, registers it and presents it on a
//   valid/ready stream. In SCAN mode (mode=0) the channels are swept 0..N-1
//   by a wrapping counter; in FIXED mode (mode=1) the host-chosen fixed_sel
//   is loaded instead and the scan counter is frozen.
//   Parameters:
//     N     number of channels (>=2, any value)
//     W     bits per channel
//     SELW  derived select width, $clog2(N); not to be overridden
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     ena        1 = new loads allowed, 0 = drain only
//     clear      synchronous: drop out_valid, scan counter -> 0, state -> IDLE
//     mode       0 = SCAN, 1 = FIXED
//     fixed_sel  channel loaded in FIXED mode (values >= N load data 0)
//     in         channel k occupies in[k*W +: W]
//     ch_mask    (only with SCAN_MUX_MASK_EN) 1 = channel included in scan
//     out_if     output stream (scan_mux_if.master)
//   Build option:
//     SCAN_MUX_MASK_EN  adds ch_mask; SCAN skips masked-off channels and
//                       out_last flags the highest enabled channel.
module scan_mux #(
  parameter  int N    = 32,
  parameter  int W    = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            clear,
  input  logic            mode,
  input  logic [SELW-1:0] fixed_sel,
  input  logic [N*W-1:0]  in,
`ifdef SCAN_MUX_MASK_EN
  input  logic [N-1:0]    ch_mask,
`endif
  scan_mux_if.master      out_if
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [SELW-1:0] cnt;
  logic [SELW-1:0] cnt_next;
  logic            valid_q;
  logic [W-1:0]    data_q;
  logic [SELW-1:0] sel_q;
  logic            last_q;

  logic            load;
  logic            has_target;
  logic [SELW-1:0] scan_sel;
  logic [SELW-1:0] last_idx;
  logic [SELW-1:0] ld_sel;
  logic [W-1:0]    ld_data;
  logic            ld_last;

`ifdef SCAN_MUX_MASK_EN
  logic [SELW-1:0] first_any;
  logic [SELW-1:0] first_ge;
  logic            found_ge;
`endif

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_sel   = sel_q;
  assign out_if.out_last  = last_q;

  // Scan target selection. The counter points at the first candidate
  // channel; with a mask the loaded channel is the first enabled one at or
  // after the counter, wrapping to the lowest enabled channel.
  always_comb begin
    scan_sel   = cnt;
    has_target = 1'b1;
    last_idx   = SELW'(N - 1);
`ifdef SCAN_MUX_MASK_EN
    first_any  = '0;
    first_ge   = '0;
    found_ge   = 1'b0;
    has_target = |ch_mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_any = SELW'(i);
        if (i >= int'(cnt)) begin
          first_ge = SELW'(i);
          found_ge = 1'b1;
        end
      end
    end
    last_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ch_mask[i]) begin
        last_idx = SELW'(i);
      end
    end
    scan_sel = found_ge ? first_ge : first_any;
`endif
  end

  // Word to load: scan or fixed select, the matching channel slice (zero
  // when no channel matches, i.e. fixed_sel >= N), and the frame-end flag.
  always_comb begin
    ld_sel  = mode ? fixed_sel : scan_sel;
    ld_last = !mode && (scan_sel == last_idx);
    ld_data = '0;
    for (int k = 0; k < N; k++) begin
      if (ld_sel == SELW'(k)) begin
        ld_data = in[k*W +: W];
      end
    end
    cnt_next = (scan_sel == SELW'(N - 1)) ? '0 : scan_sel + 1'b1;
    load     = ena && !clear && (!valid_q || out_if.out_ready) &&
               (mode || has_target);
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: DRAIN keeps the held word until it is taken, clear always
  // returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ena) next_state = RUN;
      RUN:     if (!ena) next_state = DRAIN;
      DRAIN: begin
        if (ena) begin
          next_state = RUN;
        end else if (!valid_q || out_if.out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (clear) begin
      next_state = IDLE;
    end
  end

  // Output word and scan counter. Output regs change only on a load, so a
  // stalled word stays frozen regardless of in[] or mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= 1'b0;
      cnt     <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= ld_data;
      sel_q   <= ld_sel;
      last_q  <= ld_last;
      if (!mode) begin
        cnt <= cnt_next;
      end
    end else if (out_if.out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule
